// File: rtl/blastit_pkg.sv
// blastit_pkg: character constants, line FSM encoding and upper-case helper shared by uart_line_rx.
package blastit_pkg;
    localparam logic [7:0] CR     = 8'h0D;
    localparam logic [7:0] LF     = 8'h0A;
    localparam logic [7:0] NUL    = 8'h00;
    localparam logic [7:0] PROMPT = 8'h3E;

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} line_state_t;

    function automatic logic [7:0] upcase(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
    endfunction
endpackage

// File: rtl/uart_line_rx_if.sv
// uart_line_rx_if: UART RX FIFO side and MCU line-buffer side of uart_line_rx.
interface uart_line_rx_if #(parameter int BUF_BITS = 5);
    logic                rx_empty;
    logic [7:0]          r_data;
    logic                rd_uart;
    logic                ack;
    logic [BUF_BITS-1:0] rd_addr;
    logic [7:0]          rd_data;
    logic [BUF_BITS:0]   line_len;
    logic                line_ready;
    logic                prompt_tick;
    logic                e_ovf;
    logic                done_tick;

    modport master (
        output rx_empty, r_data, ack, rd_addr,
        input  rd_uart, rd_data, line_len, line_ready, prompt_tick, e_ovf, done_tick
    );
    modport slave (
        input  rx_empty, r_data, ack, rd_addr,
        output rd_uart, rd_data, line_len, line_ready, prompt_tick, e_ovf, done_tick
    );
endinterface

// File: rtl/uart_line_rx_line_buf.sv
// line_buf: 2^ADDR_BITS x 8 RAM, synchronous write, asynchronous read, no reset.
module line_buf #(parameter int ADDR_BITS = 5) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [7:0]           i_wdata,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [7:0]           o_rdata
);
    logic [7:0] r_mem [2**ADDR_BITS];

    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_line_rx.sv
// uart_line_rx: assembles CR-terminated lines from a UART RX FIFO and holds each for the MCU until ack.
// Define UART_LINE_CASEFOLD_EN to store lower-case letters as upper case.
module uart_line_rx
    import blastit_pkg::*;
#(
    parameter int BUF_BITS = 5
) (
    input  logic           clk,
    input  logic           reset,
    uart_line_rx_if.slave  bus
);
    line_state_t       r_state, w_next;
    logic [BUF_BITS:0] r_len;
    logic              r_ovf, r_prompt, r_done;
    logic              w_rd, w_cr, w_prompt, w_skip, w_full, w_storable, w_store, w_clear;
    logic [7:0]        w_wdata;

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= FILL;
        else       r_state <= w_next;

    always_comb
        w_next = (r_state == FILL) ? ((w_rd && w_cr && r_len != '0) ? HOLD : FILL)
                                   : (bus.ack ? FILL : HOLD);

    always_comb begin
        bus.rd_uart    = (r_state == FILL) && !bus.rx_empty;
        bus.line_ready = r_state == HOLD;
    end

    assign w_rd       = bus.rd_uart;
    assign w_cr       = bus.r_data == CR;
    assign w_prompt   = bus.r_data == PROMPT;
    assign w_skip     = bus.r_data == LF || bus.r_data == NUL;
    // The count can only reach 2^BUF_BITS, so its top bit alone means full.
    assign w_full     = r_len[BUF_BITS];
    assign w_storable = w_rd && !w_cr && !w_prompt && !w_skip;
    assign w_store    = w_storable && !w_full;
    assign w_clear    = r_state == HOLD && bus.ack;

`ifdef UART_LINE_CASEFOLD_EN
    assign w_wdata = upcase(bus.r_data);
`else
    assign w_wdata = bus.r_data;
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_len    <= '0;
            r_ovf    <= 1'b0;
            r_prompt <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_len    <= w_clear ? '0 : r_len + (BUF_BITS+1)'(w_store);
            r_ovf    <= !w_clear && (r_ovf || (w_storable && w_full));
            r_prompt <= w_rd && w_prompt;
            r_done   <= w_rd && w_cr && r_len != '0;
        end

    assign bus.line_len    = r_len;
    assign bus.e_ovf       = r_ovf;
    assign bus.prompt_tick = r_prompt;
    assign bus.done_tick   = r_done;

    line_buf #(.ADDR_BITS(BUF_BITS)) u_buf (
        .clk     (clk),
        .i_we    (w_store),
        .i_waddr (r_len[BUF_BITS-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (bus.rd_addr),
        .o_rdata (bus.rd_data)
    );
endmodule

// File: doc/uart_line_rx.md
UART_LINE_RX -- requirements
Module: uart_line_rx

Interface
REQ-001 SHALL have parameter BUF_BITS, default 5, line buffer depth is 2^BUF_BITS bytes.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx_empty  input  1  UART RX FIFO empty flag.
REQ-005 SHALL have port r_data  input  8  UART RX FIFO head byte, valid when rx_empty=0.
REQ-006 SHALL have port rd_uart  output  1  UART RX FIFO pop strobe.
REQ-007 SHALL have port ack  input  1  MCU releases the held line.
REQ-008 SHALL have port rd_addr  input  BUF_BITS  MCU read address into line buffer.
REQ-009 SHALL have port rd_data  output  8  buffer byte at rd_addr, combinational read.
REQ-010 SHALL have port line_len  output  BUF_BITS+1  stored byte count, 0..2^BUF_BITS.
REQ-011 SHALL have port line_ready  output  1  complete line held for MCU.
REQ-012 SHALL have port prompt_tick  output  1  one-cycle pulse on received '>' (0x3E).
REQ-013 SHALL have port e_ovf  output  1  sticky overflow flag, bytes dropped from current line.
REQ-014 SHALL have port done_tick  output  1  one-cycle pulse when a line completes (feeds tick_counter).

Function
REQ-015 SHALL implement FSM states FILL and HOLD.
REQ-016 SHALL drive rd_uart combinationally = (state==FILL) && !rx_empty; one byte consumed per asserted cycle.
REQ-017 SHALL, on a consumed 0x0D with line_len>0, go to HOLD next cycle and pulse done_tick in that same next cycle.
REQ-018 SHALL discard a consumed 0x0D when line_len==0 (empty lines never reach HOLD).
REQ-019 SHALL discard consumed 0x0A and 0x00 bytes without effect.
REQ-020 SHALL, on a consumed 0x3E, pulse prompt_tick next cycle and not store the byte.
REQ-021 SHALL store any other consumed byte at address line_len and increment line_len next cycle.
REQ-022 SHALL, when line_len==2^BUF_BITS, drop storable bytes, hold line_len, set e_ovf; 0x0D still completes the line.
REQ-023 SHALL assert line_ready exactly while in HOLD; rd_uart SHALL be 0 in HOLD (backpressure into UART FIFO).
REQ-024 SHALL, on ack in HOLD, clear line_len and e_ovf and return to FILL next cycle; ack in FILL SHALL be ignored.
REQ-025 SHALL keep buffer contents and line_len stable throughout HOLD.
REQ-026 SHALL keep rd_data reading stale contents beyond line_len without error (no masking).

Reset
REQ-027 SHALL on reset enter FILL with line_len=0, line_ready=0, prompt_tick=0, done_tick=0, e_ovf=0; rd_uart follows REQ-016.
REQ-028 SHALL abandon any partial or held line on reset mid-operation; buffer RAM contents need not be cleared.

Configuration
REQ-029 SHALL, with UART_LINE_CASEFOLD_EN defined, store bytes 0x61..0x7A as value minus 0x20 (upper case).
REQ-030 SHALL, without UART_LINE_CASEFOLD_EN, store bytes unmodified.

Structure
REQ-031 SHALL take character constants (CR, LF, NUL, PROMPT) and FSM state encodings from shared package blastit_pkg.
REQ-032 SHALL instantiate one sub-module line_buf: 2^BUF_BITS x 8 RAM, one synchronous write port, one asynchronous read port.

Verification
REQ-033 SHALL cover: FIFO supplies "41 0D\r" -> line_len=5, line_ready=1, done_tick one pulse, rd_data[0]=0x34.
REQ-034 SHALL cover: bytes 0D 0A 0D -> line_len stays 0, never HOLD, rd_uart pulses 3 times.
REQ-035 SHALL cover: 40 bytes 0x31 then 0D with BUF_BITS=5 -> line_len=32, e_ovf=1, line_ready=1; ack -> e_ovf=0, line_len=0.
REQ-036 SHALL cover: line held, FIFO non-empty, ack delayed 10 cycles -> rd_uart=0 for all 10 cycles, consumption resumes the cycle after FILL is re-entered.
REQ-037 SHALL cover: byte 0x3E -> prompt_tick high exactly one cycle, line_len unchanged; with CASEFOLD "ok\r" -> buffer 0x4F 0x4B.
REQ-038 SHALL cover: reset asserted asynchronously mid-line after 3 bytes -> line_len=0 and line_ready=0 immediately, before the next clock edge.
